// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV (op[0]); otherwise all ops are unsigned.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t state, state_n;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   raw_a;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               div0;
    logic               neg_q;
    logic               neg_r;

    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               start_ok;
    logic               fix_ok;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

`ifdef MULDIV_SIGNED_EN
    assign sgn = op[0];
`else
    logic unused_op0;
    assign sgn        = 1'b0;
    assign unused_op0 = op[0];
`endif

    // Sign handling is done once at issue: the iterations work on magnitudes.
    assign a_neg = sgn & srcA[WIDTH-1];
    assign b_neg = sgn & srcB[WIDTH-1];
    assign a_mag = a_neg ? -srcA : srcA;
    assign b_mag = b_neg ? -srcB : srcB;

    assign busy     = (state != S_IDLE);
    assign start_ok = (state == S_IDLE) && start && !flush;
    assign fix_ok   = (state == S_FIX) && !flush;

    // Per-iteration datapath: shift-add multiply and restoring divide share acc.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, opb});
        div_diff = div_sh[WIDTH-1:0] - opb;
        div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                          : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Final sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (div0) begin
            fix_hi = raw_a;
            fix_lo = '1;
        end else begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic: flush aborts any in-flight state back to IDLE.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start_ok) state_n = op[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: begin
                if (flush)            state_n = S_IDLE;
                else if (cnt == LAST) state_n = S_FIX;
            end
            S_FIX:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Operand capture, iteration, HI/LO writeback and move-to-HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            acc    <= '0;
            opb    <= '0;
            raw_a  <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done <= fix_ok;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        acc    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                        opb    <= op[1] ? b_mag : a_mag;
                        raw_a  <= srcA;
                        cnt    <= '0;
                        is_div <= op[1];
                        div0   <= op[1] && (srcB == '0);
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                    end else if (!start) begin
                        if (mthi) hi <= srcA;
                        if (mtlo) lo <= srcA;
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (fix_ok) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit (WIDTH=32).
// Expected results follow the build selected by MULDIV_SIGNED_EN.
module tb_mips_muldiv_unit;

    localparam int W = 32;
    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;

`ifdef MULDIV_SIGNED_EN
    localparam bit SG = 1'b1;
`else
    localparam bit SG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         flush;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        int           id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .flush (flush),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every done pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done cyc=%0d hi=%h lo=%h required=no done",
                         cyc, hi, lo);
            end else begin
                e = sb.pop_front();
                if (hi !== e.hi || lo !== e.lo || cyc != e.cyc || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL op%0d got hi=%h lo=%h cyc=%0d busy=%b required hi=%h lo=%h cyc=%0d busy=0",
                             e.id, hi, lo, cyc, busy, e.hi, e.lo, e.cyc);
                end
            end
            if (prev_done === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL done_width done high two cycles at cyc=%0d required one", cyc);
            end
        end
        prev_done = done;
    end

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit push, input logic [W-1:0] eh, input logic [W-1:0] el,
                            input int id);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        if (push) sb.push_back('{eh, el, cyc + W + 2, id});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("busy_after_start%0d", id), {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_within_bound%0d", id), {31'b0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input int id);
        start_op(o, a, b, 1'b1, eh, el, id);
        wait_idle(id);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        srcA  = '0;
        srcB  = '0;
        flush = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        tick(3);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
        run_op(MULT,  32'hFFFF_FFFD, 32'd7,
               SG ? 32'hFFFF_FFFF : 32'd6, 32'hFFFF_FFEB, 2);
        run_op(DIV,   32'hFFFF_FFF9, 32'd2,
               SG ? 32'hFFFF_FFFF : 32'd1, SG ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 3);
        run_op(DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 4);
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF,
               SG ? 32'h0 : 32'h8000_0000, SG ? 32'h8000_0000 : 32'h0, 5);
        run_op(MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF,
               SG ? 32'h0 : 32'hFFFF_FFFE, 32'h1, 6);
        run_op(DIV,   32'd7, 32'hFFFF_FFFE,
               SG ? 32'd1 : 32'd7, SG ? 32'hFFFF_FFFD : 32'h0, 7);
        run_op(DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 8);
        run_op(DIVU,  32'd1000, 32'd7, 32'd6, 32'd142, 9);
        run_op(MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 10);

        // A second start while busy must be ignored.
        start_op(MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 11);
        tick(5);
        start_op(DIVU, 32'd9, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        wait_idle(11);
        tick(40);

        // Flush mid-multiply; a mtlo while busy is dropped too.
        start_op(MULTU, 32'd5, 32'd6, 1'b0, 32'd0, 32'd0, 12);
        tick(4);
        mtlo = 1'b1;
        srcA = 32'hDEAD;
        tick(1);
        mtlo = 1'b0;
        tick(3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        tick(40);
        chk("flush_hi_kept", hi, 32'd0);
        chk("flush_lo_kept", lo, 32'd12);

        mtlo = 1'b1;
        srcA = 32'h1234;
        tick(1);
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_hi_kept", hi, 32'd0);
        mthi = 1'b1;
        mtlo = 1'b1;
        srcA = 32'hA5A5;
        tick(1);
        mthi = 1'b0;
        mtlo = 1'b0;
        chk("mtboth_hi", hi, 32'hA5A5);
        chk("mtboth_lo", lo, 32'hA5A5);

        // Start beats mthi in the same cycle.
        mthi = 1'b1;
        start_op(MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 13);
        mthi = 1'b0;
        chk("start_wins_hi", hi, 32'hA5A5);
        wait_idle(13);

        // Start together with flush in IDLE does nothing.
        start = 1'b1;
        flush = 1'b1;
        op    = MULTU;
        srcA  = 32'd7;
        srcB  = 32'd7;
        tick(1);
        start = 1'b0;
        flush = 1'b0;
        chk("start_flush_busy", {31'b0, busy}, 32'd0);
        tick(40);

        // Reset mid-divide clears everything immediately.
        start_op(DIV, 32'd1000, 32'd7, 1'b0, 32'd0, 32'd0, 14);
        tick(18);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(45);
        chk("midrst_hi_after", hi, 32'h0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
